// File: rtl/ahb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter_if
// Purpose : groups the request/priority/handshake and grant signals shared
//           between the three CPU masters and the AHB master arbiter.
// Signals : req[2:0]        bus request per master (0 peri, 1 inst, 2 data)
//           hprior_0/1/2    per-master priority, larger value wins
//           hready          slave transfer-complete strobe
//           hmastlock       current owner requests a locked sequence
//           grant[2:0]      one-hot grant, zero when idle
//           hmaster[1:0]    index of current (or last) owner
//           grant_valid     any grant bit set
//           urgent[2:0]     per-master starvation flag
// Modports: master - requester side (drives requests, sees grants)
//           slave  - arbiter side (sees requests, drives grants)
// ---------------------------------------------------------------------------
interface ahb_master_arbiter_if #(
  parameter int PRIO_W = 2
);
  logic [2:0]        req;
  logic [PRIO_W-1:0] hprior_0;
  logic [PRIO_W-1:0] hprior_1;
  logic [PRIO_W-1:0] hprior_2;
  logic              hready;
  logic              hmastlock;
  logic [2:0]        grant;
  logic [1:0]        hmaster;
  logic              grant_valid;
  logic [2:0]        urgent;

  modport master (
    output req, hprior_0, hprior_1, hprior_2, hready, hmastlock,
    input  grant, hmaster, grant_valid, urgent
  );

  modport slave (
    input  req, hprior_0, hprior_1, hprior_2, hready, hmastlock,
    output grant, hmaster, grant_valid, urgent
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
// Purpose : registered arbiter sharing the single AHB-lite slave path between
//           peri (0), inst (1) and data (2). Winner selection is urgent first,
//           then highest priority, then round-robin from rr_ptr. An owner is
//           released when it drops its request or its quota expires while a
//           competitor waits, but only on hready=1 and never inside a locked
//           sequence.
// Ports   : hclk      bus clock
//           hreset_n  asynchronous active-low reset
//           bus       ahb_master_arbiter_if.slave (req, hprior_*, hready,
//                     hmastlock in; grant, hmaster, grant_valid, urgent out)
// Option  : define ARB_STARVE_GUARD_EN to add per-master age counters that
//           raise urgent[i] after AGE_MAX hready cycles of waiting.
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
  parameter int PRIO_W  = 2,
  parameter int QUOTA   = 8,
  parameter int AGE_MAX = 15
) (
  input logic hclk,
  input logic hreset_n,
  ahb_master_arbiter_if.slave bus
);

  localparam int QW = (QUOTA > 1) ? $clog2(QUOTA) : 1;
  localparam logic [QW-1:0] QUOTA_LAST = QW'(QUOTA - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state, state_n;
  logic [2:0]        grant, grant_n;
  logic [1:0]        hmaster, hmaster_n;
  logic              grant_valid;
  logic [1:0]        rr_ptr, rr_ptr_n;
  logic [QW-1:0]     quota_cnt, quota_cnt_n;
  logic [2:0]        urg;
  logic [PRIO_W-1:0] prio [3];
  logic [PRIO_W-1:0] max_prio;
  logic [2:0]        eligible, cand;
  logic [1:0]        winner;
  logic              owner_req, competitor, rearb;

  function automatic logic [1:0] rr_index(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  assign prio[0] = bus.hprior_0;
  assign prio[1] = bus.hprior_1;
  assign prio[2] = bus.hprior_2;

  // grant is zero in IDLE, so eligible is every requester there and every
  // competitor of the owner in OWN; the owner can only win again by being
  // the sole requester, which never coincides with a handover.
  assign eligible   = bus.req & ~grant;
  assign owner_req  = |(bus.req & grant);
  assign competitor = |eligible;
  assign rearb      = (state == OWN) && bus.hready && !bus.hmastlock &&
                      (!owner_req || ((quota_cnt == QUOTA_LAST) && competitor));

  // Urgent requesters form the candidate set with priority ignored; otherwise
  // the highest-priority requesters do. Scanning the rotation backwards lets
  // the first candidate at or after rr_ptr be the last assignment.
  always_comb begin
    max_prio = '0;
    cand     = eligible & urg;
    winner   = 2'd0;
    if (cand == 3'b000) begin
      for (int i = 0; i < 3; i++)
        if (eligible[i] && (prio[i] > max_prio)) max_prio = prio[i];
      for (int i = 0; i < 3; i++)
        cand[i] = eligible[i] && (prio[i] == max_prio);
    end
    for (int k = 2; k >= 0; k--)
      if (cand[rr_index(rr_ptr, k)]) winner = rr_index(rr_ptr, k);
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    hmaster_n   = hmaster;
    rr_ptr_n    = rr_ptr;
    quota_cnt_n = quota_cnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_n     = OWN;
          grant_n     = 3'b001 << winner;
          hmaster_n   = winner;
          rr_ptr_n    = rr_index(winner, 1);
          quota_cnt_n = '0;
        end
      end
      OWN: begin
        if (rearb) begin
          quota_cnt_n = '0;
          if (|bus.req) begin
            grant_n   = 3'b001 << winner;
            hmaster_n = winner;
            rr_ptr_n  = rr_index(winner, 1);
          end else begin
            state_n = IDLE;
            grant_n = 3'b000;
          end
        end else if (bus.hready && competitor && (quota_cnt != QUOTA_LAST)) begin
          quota_cnt_n = quota_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= IDLE;
      grant       <= 3'b000;
      hmaster     <= 2'd0;
      grant_valid <= 1'b0;
      rr_ptr      <= 2'd0;
      quota_cnt   <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      hmaster     <= hmaster_n;
      grant_valid <= |grant_n;
      rr_ptr      <= rr_ptr_n;
      quota_cnt   <= quota_cnt_n;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_LAST = AW'(AGE_MAX);

  logic [AW-1:0] age [3];

  // Age counts hready cycles spent requesting without a grant and saturates.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int i = 0; i < 3; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (grant[i] || !bus.req[i]) age[i] <= '0;
        else if (bus.hready && (age[i] != AGE_LAST)) age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    urg = 3'b000;
    for (int i = 0; i < 3; i++) urg[i] = (age[i] == AGE_LAST);
  end
`else
  assign urg = 3'b000;
`endif

  assign bus.grant       = grant;
  assign bus.hmaster     = hmaster;
  assign bus.grant_valid = grant_valid;
  assign bus.urgent      = urg;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_arbiter
// Purpose : directed scenarios plus randomized traffic for ahb_master_arbiter,
//           compared every cycle against a behavioural model that tracks the
//           owner as an integer (-1 when idle), the rotation pointer, quota
//           and age counts with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ahb_master_arbiter;

  localparam int QUOTA   = 8;
  localparam int AGE_MAX = 15;

  logic hclk;
  logic hreset_n;
  int   total;
  int   bad;
  bit   check_en;

  int m_owner;
  int m_hmaster;
  int m_rr;
  int m_quota;
  int m_age [3];

  ahb_master_arbiter_if #(.PRIO_W(2)) bus ();

  ahb_master_arbiter #(
    .PRIO_W (2),
    .QUOTA  (QUOTA),
    .AGE_MAX(AGE_MAX)
  ) dut (
    .hclk    (hclk),
    .hreset_n(hreset_n),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit [2:0] r, input int p0, input int p1,
                               input int p2, input bit rdy, input bit lk);
    bus.req       = r;
    bus.hprior_0  = 2'(p0);
    bus.hprior_1  = 2'(p1);
    bus.hprior_2  = 2'(p2);
    bus.hready    = rdy;
    bus.hmastlock = lk;
  endtask

  task automatic doReset();
    @(negedge hclk);
    #2 hreset_n = 1'b0;
    #1;
    @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int prioOf(input int i);
    case (i)
      0:       return int'(bus.hprior_0);
      1:       return int'(bus.hprior_1);
      default: return int'(bus.hprior_2);
    endcase
  endfunction

  function automatic bit isUrgent(input int i);
`ifdef ARB_STARVE_GUARD_EN
    return m_age[i] >= AGE_MAX;
`else
    return (i < 0);
`endif
  endfunction

  // Urgent requesters first (priority ignored), else the top-priority set;
  // then the first of the set walking 0->1->2 from the rotation pointer.
  function automatic int pickWinner(input bit [2:0] pool_in);
    bit [2:0] pool;
    int best;
    pool = 3'b000;
    best = -1;
    for (int i = 0; i < 3; i++)
      if (pool_in[i] && isUrgent(i)) pool[i] = 1'b1;
    if (pool == 3'b000) begin
      for (int i = 0; i < 3; i++)
        if (pool_in[i] && prioOf(i) > best) best = prioOf(i);
      for (int i = 0; i < 3; i++)
        pool[i] = pool_in[i] && (prioOf(i) == best);
    end
    for (int k = 0; k < 3; k++)
      if (pool[(m_rr + k) % 3]) return (m_rr + k) % 3;
    return -1;
  endfunction

  task automatic modelStep();
    bit [2:0] r;
    bit [2:0] rivals;
    bit       release_now;
    int       old_owner;
    int       w;
    r         = bus.req;
    old_owner = m_owner;
    rivals    = r;
    if (m_owner >= 0) rivals[m_owner] = 1'b0;
    w = pickWinner(rivals);
    if (m_owner < 0) begin
      if (r != 3'b000) begin
        m_owner = w; m_hmaster = w; m_rr = (w + 1) % 3; m_quota = 0;
      end
    end else begin
      release_now = bus.hready && !bus.hmastlock &&
                    (!r[m_owner] || (m_quota == QUOTA - 1 && rivals != 3'b000));
      if (release_now) begin
        m_quota = 0;
        if (rivals != 3'b000) begin
          m_owner = w; m_hmaster = w; m_rr = (w + 1) % 3;
        end else begin
          m_owner = -1;
        end
      end else if (bus.hready && rivals != 3'b000 && m_quota < QUOTA - 1) begin
        m_quota++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!r[i] || old_owner == i) m_age[i] = 0;
      else if (bus.hready && m_age[i] < AGE_MAX) m_age[i]++;
    end
  endtask

  always @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      m_owner = -1; m_hmaster = 0; m_rr = 0; m_quota = 0;
      for (int i = 0; i < 3; i++) m_age[i] = 0;
    end else begin
      modelStep();
    end
  end

  function automatic int expGrant();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  function automatic int expUrgent();
    int u;
    u = 0;
    for (int i = 0; i < 3; i++) if (isUrgent(i)) u |= (1 << i);
    return u;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge hclk) begin
    if (check_en && hreset_n) begin
      checkOutput("cmp_grant",       32'(bus.grant),       32'(expGrant()));
      checkOutput("cmp_hmaster",     32'(bus.hmaster),     32'(m_hmaster));
      checkOutput("cmp_grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
      checkOutput("cmp_urgent",      32'(bus.urgent),      32'(expUrgent()));
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    total    = 0;
    bad      = 0;
    check_en = 1'b0;
    hreset_n = 1'b1;
    applyStimulus(3'b000, 0, 0, 0, 1'b1, 1'b0);
    #1 hreset_n = 1'b0;
    #2;
    checkOutput("reset_grant",       32'(bus.grant),       0);
    checkOutput("reset_hmaster",     32'(bus.hmaster),     0);
    checkOutput("reset_grant_valid", 32'(bus.grant_valid), 0);
    checkOutput("reset_urgent",      32'(bus.urgent),      0);
    @(negedge hclk);
    hreset_n = 1'b1;
    check_en = 1'b1;

    $display("[TB] single requester grant and release");
    applyStimulus(3'b010, 0, 0, 0, 1'b1, 1'b0);
    @(negedge hclk);
    checkOutput("t1_grant",       32'(bus.grant),   32'b010);
    checkOutput("t1_hmaster",     32'(bus.hmaster), 1);
    checkOutput("t1_model_owner", 32'(m_owner),     1);
    applyStimulus(3'b000, 0, 0, 0, 1'b1, 1'b0);
    @(negedge hclk);
    checkOutput("t1_idle_grant",   32'(bus.grant),       0);
    checkOutput("t1_idle_valid",   32'(bus.grant_valid), 0);
    checkOutput("t1_idle_hmaster", 32'(bus.hmaster),     1);

    $display("[TB] priority then quota handover");
    doReset();
    applyStimulus(3'b111, 1, 3, 2, 1'b1, 1'b0);
    for (int k = 0; k <= 16; k++) begin
      @(negedge hclk);
      checkOutput($sformatf("t2_grant_%0d", k), 32'(bus.grant),
                  (k < 8) ? 32'b010 : (k < 16) ? 32'b100 : 32'b010);
    end

    $display("[TB] equal priority rotation");
    doReset();
    applyStimulus(3'b111, 0, 0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) begin
      @(negedge hclk);
      checkOutput($sformatf("t3_grant_%0d", k), 32'(bus.grant), 32'(1 << ((k / 8) % 3)));
    end

    $display("[TB] locked ownership");
    doReset();
    applyStimulus(3'b001, 0, 0, 0, 1'b1, 1'b0);
    @(negedge hclk);
    checkOutput("t4_first", 32'(bus.grant), 32'b001);
    applyStimulus(3'b101, 0, 0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge hclk);
      checkOutput($sformatf("t4_locked_%0d", k), 32'(bus.grant), 32'b001);
    end
    applyStimulus(3'b101, 0, 0, 0, 1'b1, 1'b0);
    @(negedge hclk);
    checkOutput("t4_unlock", 32'(bus.grant), 32'b100);

    $display("[TB] release waits for hready, async reset");
    applyStimulus(3'b001, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      checkOutput($sformatf("t5_wait_%0d", k), 32'(bus.grant), 32'b100);
    end
    applyStimulus(3'b001, 0, 0, 0, 1'b1, 1'b0);
    @(negedge hclk);
    checkOutput("t5_handover", 32'(bus.grant), 32'b001);
    #2 hreset_n = 1'b0;
    #1;
    checkOutput("t5_async_grant", 32'(bus.grant),       0);
    checkOutput("t5_async_valid", 32'(bus.grant_valid), 0);
    @(negedge hclk);
    hreset_n = 1'b1;

    $display("[TB] high priority data versus peri");
    applyStimulus(3'b101, 0, 0, 3, 1'b1, 1'b0);
    for (int k = 0; k <= 16; k++) begin
      @(negedge hclk);
      checkOutput($sformatf("t6_grant_%0d", k), 32'(bus.grant),
                  (k < 8) ? 32'b100 : (k < 16) ? 32'b001 : 32'b100);
      checkOutput($sformatf("t6_urgent_%0d", k), 32'(bus.urgent), 0);
    end

    $display("[TB] randomized traffic");
    for (int n = 0; n < 4000; n++) begin
      @(negedge hclk);
      if ($urandom_range(0, 599) == 0) doReset();
      applyStimulus({($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
                     ($urandom_range(0, 99) < 70)},
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : int'(bus.hprior_0),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : int'(bus.hprior_1),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : int'(bus.hprior_2),
                    ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 10));
    end

    @(negedge hclk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
